// File: rtl/alu_exec_ctrl_if.sv
// Handshake and bus bundle between the ALU command sequencer, the packet parser,
// the shared mul/div units and the transmit framer.
interface alu_exec_ctrl_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [1:0]       cmd_op_i;
  logic [CNT_W-1:0] cmd_count_i;
  logic             opnd_valid_i;
  logic             opnd_ready_o;
  logic [WIDTH-1:0] opnd_data_i;
  logic             mul_start_o;
  logic [WIDTH-1:0] mul_a_o;
  logic [WIDTH-1:0] mul_b_o;
  logic             mul_done_i;
  logic [WIDTH-1:0] mul_result_i;
  logic             div_start_o;
  logic [WIDTH-1:0] div_a_o;
  logic [WIDTH-1:0] div_b_o;
  logic             div_done_i;
  logic [WIDTH-1:0] div_quot_i;
  logic             res_valid_o;
  logic             res_ready_i;
  logic [WIDTH-1:0] res_data_o;
  logic             res_err_o;
  logic             busy_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, cmd_count_i, opnd_valid_i, opnd_data_i,
    input  mul_done_i, mul_result_i, div_done_i, div_quot_i, res_ready_i,
    output cmd_ready_o, opnd_ready_o, mul_start_o, mul_a_o, mul_b_o,
    output div_start_o, div_a_o, div_b_o, res_valid_o, res_data_o, res_err_o, busy_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, cmd_count_i, opnd_valid_i, opnd_data_i,
    output mul_done_i, mul_result_i, div_done_i, div_quot_i, res_ready_i,
    input  cmd_ready_o, opnd_ready_o, mul_start_o, mul_a_o, mul_b_o,
    input  div_start_o, div_a_o, div_b_o, res_valid_o, res_data_o, res_err_o, busy_o
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Command sequencer: folds an operand stream into a 32-bit accumulator, adding in-block
// and issuing mul/div to shared multi-cycle units, then presents the result.
module alu_exec_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  alu_exec_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle, StFirst, StNext, StIssue, StWait, StResult
  } state_e;

  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  state_e           r_state, w_state_d;
  logic [1:0]       r_op, w_op_d;
  logic [CNT_W-1:0] r_rem, w_rem_d;
  logic [WIDTH-1:0] r_acc, w_acc_d;
  logic [WIDTH-1:0] r_b, w_b_d;
  logic             r_err, w_err_d;
  logic             r_live;

  logic w_cmd_ready, w_opnd_ready, w_cmd_hs, w_opnd_hs, w_last, w_done;

  // r_live keeps cmd_ready_o low while reset is held, even though the state is IDLE.
  assign w_cmd_ready  = r_live && (r_state == StIdle);
  assign w_opnd_ready = (r_state == StFirst) || (r_state == StNext);
  assign w_cmd_hs     = bus.cmd_valid_i && w_cmd_ready;
  assign w_opnd_hs    = bus.opnd_valid_i && w_opnd_ready;
  assign w_last       = (r_rem == CNT_W'(1));
  assign w_done       = ((r_op == OpMul) && bus.mul_done_i) || ((r_op == OpDiv) && bus.div_done_i);

  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_rem_d   = r_rem;
    w_acc_d   = r_acc;
    w_b_d     = r_b;
    w_err_d   = r_err;
    unique case (r_state)
      StIdle: begin
        if (w_cmd_hs) begin
          w_op_d  = bus.cmd_op_i;
          w_rem_d = bus.cmd_count_i;
          w_acc_d = '0;
          w_err_d = (bus.cmd_op_i == 2'b00);
          if (bus.cmd_count_i == '0) begin
            w_state_d = StResult;
          end else if (bus.cmd_op_i == 2'b00) begin
            w_state_d = StNext;
          end else begin
            w_state_d = StFirst;
          end
        end
      end
      StFirst: begin
        if (w_opnd_hs) begin
          w_acc_d   = bus.opnd_data_i;
          w_rem_d   = r_rem - CNT_W'(1);
          w_state_d = w_last ? StResult : StNext;
        end
      end
      StNext: begin
        if (w_opnd_hs) begin
          w_rem_d   = r_rem - CNT_W'(1);
          w_state_d = w_last ? StResult : StNext;
          case (r_op)
            OpAdd: w_acc_d = r_acc + bus.opnd_data_i;
            OpMul: begin
              w_b_d     = bus.opnd_data_i;
              w_state_d = StIssue;
            end
            OpDiv: begin
              if (bus.opnd_data_i == '0) begin
                w_acc_d = '1;
                w_err_d = 1'b1;
              end else begin
                w_b_d     = bus.opnd_data_i;
                w_state_d = StIssue;
              end
            end
            default: ;  // illegal opcode: operand is drained, accumulator untouched
          endcase
        end
      end
      StIssue: w_state_d = StWait;
      StWait: begin
        if (w_done) begin
          w_acc_d   = (r_op == OpMul) ? bus.mul_result_i : bus.div_quot_i;
          w_state_d = (r_rem == '0) ? StResult : StNext;
        end
      end
      StResult: begin
        if (bus.res_ready_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_op    <= 2'b00;
      r_rem   <= '0;
      r_acc   <= '0;
      r_b     <= '0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_op    <= w_op_d;
      r_rem   <= w_rem_d;
      r_acc   <= w_acc_d;
      r_b     <= w_b_d;
      r_err   <= w_err_d;
      r_live  <= 1'b1;
    end
  end

  assign bus.cmd_ready_o  = w_cmd_ready;
  assign bus.opnd_ready_o = w_opnd_ready;
  assign bus.mul_start_o  = (r_state == StIssue) && (r_op == OpMul);
  assign bus.div_start_o  = (r_state == StIssue) && (r_op == OpDiv);
  assign bus.mul_a_o      = r_acc;
  assign bus.mul_b_o      = r_b;
  assign bus.div_a_o      = r_acc;
  assign bus.div_b_o      = r_b;
  assign bus.res_valid_o  = (r_state == StResult);
  assign bus.res_data_o   = r_acc;
  assign bus.res_err_o    = r_err;
  assign bus.busy_o       = (r_state != StIdle);

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: directed vector table, timing/back-pressure/reset sequences
// and random commands checked against a fold-style reference model.
module tb_alu_exec_ctrl;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  typedef logic [31:0] ops_t [8];
  typedef struct {
    logic [1:0]  op;
    int          cnt;
    ops_t        ops;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_mul;
    int          exp_div;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  alu_exec_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Multi-cycle unit models with programmable latency.
  int          mul_lat = 4, div_lat = 3;
  int          mul_timer = 0, div_timer = 0;
  logic        r_mul_done = 1'b0, r_div_done = 1'b0, x_mul_done = 1'b0;
  logic [31:0] r_mul_res = '0, r_div_res = '0;
  logic [31:0] mul_a_cap = '0, mul_b_cap = '0, div_a_cap = '0, div_b_cap = '0;
  int          mul_bad = 0, div_bad = 0;
  int          mul_starts = 0, div_starts = 0, opnd_hs = 0;

  assign bus.mul_done_i   = r_mul_done | x_mul_done;
  assign bus.mul_result_i = r_mul_res;
  assign bus.div_done_i   = r_div_done;
  assign bus.div_quot_i   = r_div_res;

  always @(posedge clk) begin
    r_mul_done <= 1'b0;
    if (!rst_n) begin
      mul_timer <= 0;
    end else if (mul_timer == 1) begin
      r_mul_done <= 1'b1;
      r_mul_res  <= mul_a_cap * mul_b_cap;
      mul_timer  <= 0;
      if (bus.mul_a_o !== mul_a_cap || bus.mul_b_o !== mul_b_cap) mul_bad <= mul_bad + 1;
    end else if (mul_timer > 1) begin
      mul_timer <= mul_timer - 1;
      if (bus.mul_a_o !== mul_a_cap || bus.mul_b_o !== mul_b_cap) mul_bad <= mul_bad + 1;
    end else if (bus.mul_start_o) begin
      mul_a_cap <= bus.mul_a_o;
      mul_b_cap <= bus.mul_b_o;
      mul_timer <= mul_lat;
    end
  end

  always @(posedge clk) begin
    r_div_done <= 1'b0;
    if (!rst_n) begin
      div_timer <= 0;
    end else if (div_timer == 1) begin
      r_div_done <= 1'b1;
      r_div_res  <= (div_b_cap == 0) ? 32'hFFFF_FFFF : div_a_cap / div_b_cap;
      div_timer  <= 0;
      if (bus.div_a_o !== div_a_cap || bus.div_b_o !== div_b_cap) div_bad <= div_bad + 1;
    end else if (div_timer > 1) begin
      div_timer <= div_timer - 1;
      if (bus.div_a_o !== div_a_cap || bus.div_b_o !== div_b_cap) div_bad <= div_bad + 1;
    end else if (bus.div_start_o) begin
      div_a_cap <= bus.div_a_o;
      div_b_cap <= bus.div_b_o;
      div_timer <= div_lat;
    end
  end

  always @(posedge clk) begin
    if (bus.mul_start_o) mul_starts <= mul_starts + 1;
    if (bus.div_start_o) div_starts <= div_starts + 1;
    if (bus.opnd_valid_i && bus.opnd_ready_o) opnd_hs <= opnd_hs + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT, got no response, expected a handshake", name);
  endtask

  // Reference: left fold of the operand list under the command's rules.
  task automatic ref_model(input logic [1:0] op, input int cnt, input ops_t ops,
                           output logic [31:0] data, output logic err,
                           output int nmul, output int ndiv);
    data = '0; err = (op == 2'b00); nmul = 0; ndiv = 0;
    if (cnt == 0 || op == 2'b00) return;
    data = ops[0];
    for (int i = 1; i < cnt; i++) begin
      if (op == 2'b01) begin
        data = data + ops[i];
      end else if (op == 2'b10) begin
        data = data * ops[i];
        nmul++;
      end else if (ops[i] == 0) begin
        data = 32'hFFFF_FFFF;
        err  = 1'b1;
      end else begin
        data = data / ops[i];
        ndiv++;
      end
    end
  endtask

  task automatic wait_cmd_ready(output logic ok);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    ok = bus.cmd_ready_o;
  endtask

  task automatic send_opnd(input logic [31:0] d, output logic ok);
    int n = 0;
    bus.opnd_valid_i = 1'b1;
    bus.opnd_data_i  = d;
    @(negedge clk);
    while (!bus.opnd_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    ok = bus.opnd_ready_o;
    @(posedge clk);
    #1 bus.opnd_valid_i = 1'b0;
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input int cnt, input ops_t ops,
                        input logic [31:0] exp_data, input logic exp_err,
                        input int exp_mul, input int exp_div, input int gap_max, input int rdy_max);
    int m0 = mul_starts, d0 = div_starts, o0 = opnd_hs, mb0 = mul_bad, db0 = div_bad;
    logic ok, got_res;
    logic [31:0] data;
    logic err;
    data = '0; err = 1'b0; got_res = 1'b0;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_count_i = CNT_W'(cnt);
    wait_cmd_ready(ok);
    if (!ok) begin
      bus.cmd_valid_i = 1'b0;
      timeout({name, "_cmd"});
      return;
    end
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    fork
      begin
        for (int i = 0; i < cnt; i++) begin
          logic sent;
          repeat ($urandom_range(0, gap_max)) @(posedge clk);
          #0 send_opnd(ops[i], sent);
          if (!sent) begin
            timeout({name, "_opnd"});
            break;
          end
        end
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!bus.res_valid_o && n < 3000) begin
          n++;
          @(negedge clk);
        end
        if (bus.res_valid_o) begin
          repeat ($urandom_range(0, rdy_max)) @(negedge clk);
          data    = bus.res_data_o;
          err     = bus.res_err_o;
          got_res = 1'b1;
          bus.res_ready_i = 1'b1;
          @(posedge clk);
          #1 bus.res_ready_i = 1'b0;
        end else begin
          timeout({name, "_res"});
        end
      end
    join
    if (!got_res) return;
    check({name, "_data"}, data, exp_data);
    check({name, "_err"}, err, exp_err);
    check({name, "_nmul"}, mul_starts - m0, exp_mul);
    check({name, "_ndiv"}, div_starts - d0, exp_div);
    check({name, "_nopnd"}, opnd_hs - o0, cnt);
    check({name, "_ab_stable"}, (mul_bad - mb0) + (div_bad - db0), 0);
  endtask

  vec_t tbl[9];

  task automatic set_vec(input int idx, input logic [1:0] op, input int cnt,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] ed, input logic ee, input int em, input int edv);
    tbl[idx].op = op;
    tbl[idx].cnt = cnt;
    for (int i = 0; i < 8; i++) tbl[idx].ops[i] = '0;
    tbl[idx].ops[0] = a0;
    tbl[idx].ops[1] = a1;
    tbl[idx].ops[2] = a2;
    tbl[idx].exp_data = ed;
    tbl[idx].exp_err = ee;
    tbl[idx].exp_mul = em;
    tbl[idx].exp_div = edv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic        ok;
    ops_t        rops;
    logic [31:0] ed;
    logic        ee;
    int          em, edv;

    bus.cmd_valid_i = 1'b0;  bus.cmd_op_i = 2'b00;  bus.cmd_count_i = '0;
    bus.opnd_valid_i = 1'b0; bus.opnd_data_i = '0;  bus.res_ready_i = 1'b0;

    #2;
    check("reset_outputs",
          {bus.cmd_ready_o, bus.opnd_ready_o, bus.mul_start_o, bus.div_start_o,
           bus.res_valid_o, bus.res_err_o, bus.busy_o}, 7'd0);
    check("reset_ab", {bus.mul_a_o, bus.mul_b_o}, 64'd0);
    check("reset_res_data", bus.res_data_o, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_vec(0, 2'b01, 3, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'h0000_000B, 1'b0, 0, 0);
    set_vec(1, 2'b10, 2, 32'h1_0000, 32'h1_0001, 32'd0, 32'h0001_0000, 1'b0, 1, 0);
    set_vec(2, 2'b11, 3, 32'd100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b1, 0, 1);
    set_vec(3, 2'b00, 2, 32'd3, 32'd4, 32'd0, 32'd0, 1'b1, 0, 0);
    set_vec(4, 2'b01, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
    set_vec(5, 2'b10, 1, 32'd123, 32'd0, 32'd0, 32'd123, 1'b0, 0, 0);
    set_vec(6, 2'b11, 3, 32'd1000, 32'd10, 32'd3, 32'd33, 1'b0, 0, 2);
    set_vec(7, 2'b11, 2, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 0, 1);
    set_vec(8, 2'b10, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b0, 1, 0);
    for (int i = 0; i < 9; i++) begin
      do_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].cnt, tbl[i].ops, tbl[i].exp_data,
             tbl[i].exp_err, tbl[i].exp_mul, tbl[i].exp_div, i % 3, i % 2);
    end

    // Add timing: continuous valid, no bubbles, result the cycle after the 3rd handshake,
    // then ten cycles of result back-pressure.
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b01; bus.cmd_count_i = CNT_W'(3);
    wait_cmd_ready(ok);
    check("seq_add_cmd_ready", ok, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b0;
    bus.opnd_valid_i = 1'b1;
    bus.opnd_data_i = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("seq_add_ready%0d", i), bus.opnd_ready_o, 1'b1);
      check($sformatf("seq_add_novalid%0d", i), bus.res_valid_o, 1'b0);
      @(posedge clk);
      #1;
      if (i == 0) bus.opnd_data_i = 32'd7;
      else if (i == 1) bus.opnd_data_i = 32'hFFFF_FFFF;
      else bus.opnd_valid_i = 1'b0;
    end
    check("seq_add_res_valid", bus.res_valid_o, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i),
            {bus.res_valid_o, bus.res_err_o, bus.cmd_ready_o, bus.res_data_o},
            {1'b1, 1'b0, 1'b0, 32'h0000_000B});
    end
    bus.res_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready_i = 1'b0;
    check("bp_release_idle", {bus.busy_o, bus.res_valid_o, bus.cmd_ready_o}, 3'b001);

    // Reset during the WAIT of a multiply, then a late done that must be ignored.
    mul_lat = 20;
    @(posedge clk);
    #1;
    bus.cmd_valid_i = 1'b1; bus.cmd_op_i = 2'b10; bus.cmd_count_i = CNT_W'(2);
    wait_cmd_ready(ok);
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    send_opnd(32'd3, ok);
    send_opnd(32'd4, ok);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl",
          {bus.cmd_ready_o, bus.opnd_ready_o, bus.mul_start_o, bus.div_start_o,
           bus.res_valid_o, bus.res_err_o, bus.busy_o}, 7'd0);
    check("rst_mid_ab", {bus.mul_a_o, bus.mul_b_o}, 64'd0);
    check("rst_mid_res", bus.res_data_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mul_lat = 4;
    repeat (2) @(posedge clk);
    #1 x_mul_done = 1'b1;
    @(posedge clk);
    #1 x_mul_done = 1'b0;
    @(negedge clk);
    check("late_done_ignored", {bus.busy_o, bus.res_valid_o, bus.cmd_ready_o}, 3'b001);
    for (int i = 0; i < 8; i++) rops[i] = '0;
    rops[0] = 32'd10; rops[1] = 32'd20; rops[2] = 32'd30;
    do_cmd("post_rst_add", 2'b01, 3, rops, 32'd60, 1'b0, 0, 0, 1, 1);

    // Random commands against the reference fold.
    for (int k = 0; k < 40; k++) begin
      int r = $urandom_range(0, 9);
      logic [1:0] op = (r == 0) ? 2'b00 : 2'(1 + (r % 3));
      int cnt = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) begin
        int sel = $urandom_range(0, 9);
        if (sel < 2) rops[i] = '0;
        else if (sel < 5) rops[i] = 32'($urandom_range(1, 20));
        else rops[i] = $urandom;
      end
      mul_lat = $urandom_range(1, 6);
      div_lat = $urandom_range(1, 6);
      ref_model(op, cnt, rops, ed, ee, em, edv);
      do_cmd($sformatf("rnd%0d", k), op, cnt, rops, ed, ee, em, edv, 2, 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Command sequencer for the UART ALU arithmetic datapath. It takes a decoded command (opcode plus operand count) and an operand stream from the packet parser. It folds the operands left to right into a 32-bit accumulator: additions are done in-block, and multiplications and divisions are issued to shared multi-cycle multiplier and divider units over a start/done handshake. The final accumulator is presented on a valid/ready result port that feeds the UART transmit framer.

## Interface
- WIDTH, 32, operand/accumulator/result width
- CNT_W, 8, width of operand count
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i
- cmd_op_i  in  2  2'b01 add, 2'b10 mul, 2'b11 div, 2'b00 illegal
- cmd_count_i  in  CNT_W  number of operands in the command
- opnd_valid_i  in  1  operand valid
- opnd_ready_o  out  1  operand accepted
- opnd_data_i  in  WIDTH  operand, unsigned
- mul_start_o  out  1  one-cycle start pulse to multiplier
- mul_a_o, mul_b_o  out  WIDTH  multiplier operands
- mul_done_i  in  1  multiplier result valid (one-cycle pulse)
- mul_result_i  in  WIDTH  low WIDTH bits of product
- div_start_o  out  1  one-cycle start pulse to divider
- div_a_o, div_b_o  out  WIDTH  dividend, divisor
- div_done_i  in  1  divider result valid (one-cycle pulse)
- div_quot_i  in  WIDTH  quotient
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumer ready
- res_data_o  out  WIDTH  final accumulator
- res_err_o  out  1  illegal opcode or divide-by-zero occurred in this command
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, FIRST, NEXT, ISSUE, WAIT, RESULT.
- IDLE: cmd_ready_o=1. On handshake, latch op, set remaining=cmd_count_i, and clear err.
  - count 0: go to RESULT with acc=0.
  - Illegal op: set err and drain operands as in NEXT without computing; acc stays 0.
  - Otherwise go to FIRST.
- FIRST: opnd_ready_o=1. On handshake, acc=opnd_data_i and remaining-1. If remaining becomes 0, go to RESULT; else go to NEXT.
- NEXT: opnd_ready_o=1. On handshake with remaining-1:
  - add: acc=acc+opnd_data_i mod 2^WIDTH. Stay in NEXT, or go to RESULT if remaining reaches 0.
  - mul: latch operand into b, go to ISSUE.
  - div, operand≠0: latch operand into b, go to ISSUE.
  - div, operand==0: acc=all-ones, err=1, no unit issue. Go to NEXT or RESULT.
- ISSUE: assert exactly one of mul_start_o/div_start_o for one cycle, then go to WAIT.
- WAIT: on the matching done_i, acc=result (mul_result_i or div_quot_i), then go to NEXT, or RESULT if remaining==0.
- *_a_o=acc and *_b_o=b are held stable from ISSUE through the done cycle.
- RESULT: res_valid_o=1, res_data_o=acc, res_err_o=err, all held stable. On res_ready_i, go to IDLE.
- done_i outside WAIT, and the non-matching unit's done_i, are ignored.

## Timing
- Reset values:
  - All *_o low.
  - *_a_o, *_b_o, res_data_o are 0.
  - State is IDLE, acc=0, remaining=0, err=0.
- Reset asserted mid-operation aborts immediately: a start pulse in flight is dropped, and no result is produced. The units share rst_ni.
- cmd_ready_o and opnd_ready_o are state-decoded only, with no combinational path from *_valid_i.
- Add throughput: one operand per cycle in NEXT, with no bubbles.
- Mul/div per operand: handshake cycle, then ISSUE (1 cycle), then WAIT (≥1 cycle, unit-defined). The next operand is accepted the cycle after done.
- A done_i in the same cycle as start is not allowed; units have ≥1 cycle latency.
- Result latency: res_valid_o rises the cycle after the last operand handshake (add or single operand) or the cycle after the last done_i.
- res_valid_o stays high until res_ready_i; a new command is accepted no earlier than the cycle after the result handshake.
- Arithmetic is unsigned, mod 2^WIDTH. Products keep the low WIDTH bits. Division truncates.

## Test plan
- Add, 3 operands 5, 7, 0xFFFFFFFF with continuous valid -> res_data_o=0x0000000B, err=0; res_valid_o the cycle after the 3rd handshake.
- Mul, 2 operands 0x10000, 0x10001 -> one mul_start_o pulse with a=0x10000, b=0x10001.
  - Model returns 0x10000 after 4 cycles.
  - res_data_o=0x00010000, err=0, div_start_o never high.
- Div, 3 operands 100, 7, 0 -> first quotient 14, then divide-by-zero -> res_data_o=0xFFFFFFFF, res_err_o=1, exactly one div_start_o.
- Opcode 2'b00, count 2 -> both operands drained, res_data_o=0, err=1; count 0 with add -> immediate result 0, no opnd_ready_o handshake.
- Result back-pressure: hold res_ready_i low 10 cycles -> data/err stable, cmd_ready_o low; release -> IDLE next cycle.
- rst_ni low during WAIT of a mul -> all outputs 0 asynchronously, a late mul_done_i after release is ignored, and a fresh add command completes correctly.
